// File: rtl/bcd_scan_display_if.sv
// Producer-to-display handshake bundle for bcd_scan_display.
// The master modport drives the word, the slave modport returns in_ready.
interface bcd_scan_display_if;
   localparam int unsigned WORD_W = 16;
   localparam int unsigned DIGITS = 4;

   logic              in_valid;
   logic              in_ready;
   logic [WORD_W-1:0] bcd_in;
   logic [DIGITS-1:0] dp_in;
   logic              blank_in;

   modport master (output in_valid, bcd_in, dp_in, blank_in, input in_ready);
   modport slave  (input in_valid, bcd_in, dp_in, blank_in, output in_ready);
endinterface

// File: rtl/bcd_scan_display.sv
// Double-buffered, time-multiplexed 4-digit seven-segment driver for BCD words.
// Optional macro SCAN_DIMMING_EN adds a 2-bit bright input that limits duty per digit slot.
module bcd_scan_display #(
   parameter int unsigned SCAN_DIV = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   bcd_scan_display_if.slave bus,
`ifdef SCAN_DIMMING_EN
   input  logic [1:0]        bright,
`endif
   output logic [6:0]        seg_n,
   output logic              dp_n,
   output logic [3:0]        dig_n,
   output logic              err
);
   localparam int unsigned PW     = SCAN_DIV;
   localparam int unsigned WORD_W = 16;
   localparam int unsigned DIGITS = 4;

   // Segment pattern {g,f,e,d,c,b,a}, active low; non-BCD nibbles show "E"
   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      case (v)
         4'd0:    return 7'h40;
         4'd1:    return 7'h79;
         4'd2:    return 7'h24;
         4'd3:    return 7'h30;
         4'd4:    return 7'h19;
         4'd5:    return 7'h12;
         4'd6:    return 7'h02;
         4'd7:    return 7'h78;
         4'd8:    return 7'h00;
         4'd9:    return 7'h10;
         default: return 7'h06;
      endcase
   endfunction

   // True when any nibble of the word is outside 0..9
   function automatic logic has_bad_nibble(input logic [WORD_W-1:0] w);
      logic bad;
      bad = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         if (w[4*k +: 4] > 4'd9) bad = 1'b1;
      end
      return bad;
   endfunction

   logic [PW-1:0]     pre_q,        pre_nxt;
   logic [1:0]        idx_q,        idx_nxt;
   logic              ready_q,      ready_nxt;
   logic [WORD_W-1:0] pend_word_q,  pend_word_nxt;
   logic [DIGITS-1:0] pend_dp_q,    pend_dp_nxt;
   logic              pend_blank_q, pend_blank_nxt;
   logic [WORD_W-1:0] shd_word_q,   shd_word_nxt;
   logic [DIGITS-1:0] shd_dp_q,     shd_dp_nxt;
   logic              shd_blank_q,  shd_blank_nxt;
   logic              err_nxt;
   logic [6:0]        seg_nxt;
   logic              dp_nxt;
   logic [3:0]        dig_nxt;

   logic              tick_c, frame_end_c, xfer_c, lit_c, blank_dig_c;
   logic [3:0]        nib_c [DIGITS];
   logic [DIGITS-1:0] lz_c;

   assign bus.in_ready = ready_q;

   // Next-state: prescaler/scan, handshake buffers, sticky error and display outputs
   always_comb begin
      pre_nxt        = pre_q + PW'(1);
      idx_nxt        = idx_q;
      ready_nxt      = ready_q;
      pend_word_nxt  = pend_word_q;
      pend_dp_nxt    = pend_dp_q;
      pend_blank_nxt = pend_blank_q;
      shd_word_nxt   = shd_word_q;
      shd_dp_nxt     = shd_dp_q;
      shd_blank_nxt  = shd_blank_q;
      err_nxt        = err;

      tick_c      = &pre_q;
      frame_end_c = tick_c && (idx_q == 2'd3);
      xfer_c      = bus.in_valid && ready_q;

      if (tick_c) idx_nxt = idx_q + 2'd1;

      // Pending is only full when ready is low, so the two cases never collide
      if (frame_end_c && !ready_q) begin
         shd_word_nxt  = pend_word_q;
         shd_dp_nxt    = pend_dp_q;
         shd_blank_nxt = pend_blank_q;
         ready_nxt     = 1'b1;
      end
      if (xfer_c) begin
         pend_word_nxt  = bus.bcd_in;
         pend_dp_nxt    = bus.dp_in;
         pend_blank_nxt = bus.blank_in;
         ready_nxt      = 1'b0;
         if (has_bad_nibble(bus.bcd_in)) err_nxt = 1'b1;
      end

      for (int k = 0; k < DIGITS; k++) nib_c[k] = shd_word_nxt[4*k +: 4];

      // lz_c[k]: digit k and every digit above it are zero
      lz_c[3] = (nib_c[3] == 4'd0);
      lz_c[2] = lz_c[3] && (nib_c[2] == 4'd0);
      lz_c[1] = lz_c[2] && (nib_c[1] == 4'd0);
      lz_c[0] = 1'b0;
      blank_dig_c = shd_blank_nxt && lz_c[idx_nxt];

      lit_c = (pre_nxt != '0);
`ifdef SCAN_DIMMING_EN
      lit_c = lit_c && (pre_nxt[PW-1 -: 2] <= bright);
`endif

      seg_nxt = 7'h7F;
      dp_nxt  = 1'b1;
      dig_nxt = 4'hF;
      if (lit_c) begin
         dig_nxt = ~(4'b0001 << idx_nxt);
         dp_nxt  = ~shd_dp_nxt[idx_nxt];
         seg_nxt = blank_dig_c ? 7'h7F : seg_decode(nib_c[idx_nxt]);
      end
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q        <= '0;
         idx_q        <= 2'd0;
         ready_q      <= 1'b1;
         pend_word_q  <= '0;
         pend_dp_q    <= '0;
         pend_blank_q <= 1'b0;
         shd_word_q   <= '0;
         shd_dp_q     <= '0;
         shd_blank_q  <= 1'b0;
         err          <= 1'b0;
         seg_n        <= 7'h7F;
         dp_n         <= 1'b1;
         dig_n        <= 4'hF;
      end else begin
         pre_q        <= pre_nxt;
         idx_q        <= idx_nxt;
         ready_q      <= ready_nxt;
         pend_word_q  <= pend_word_nxt;
         pend_dp_q    <= pend_dp_nxt;
         pend_blank_q <= pend_blank_nxt;
         shd_word_q   <= shd_word_nxt;
         shd_dp_q     <= shd_dp_nxt;
         shd_blank_q  <= shd_blank_nxt;
         err          <= err_nxt;
         seg_n        <= seg_nxt;
         dp_n         <= dp_nxt;
         dig_n        <= dig_nxt;
      end
   end
endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
- Display-side consumer of the BCD digit values produced by the 0–9 switch counters.
- Accepts a 4-digit packed BCD word through a valid/ready handshake and double-buffers it.
- Drives one time-multiplexed, active-low 4-digit seven-segment display.
- Provides leading-zero blanking, dead-time ghost suppression and sticky invalid-digit flagging.

Parameters:
- SCAN_DIV, 16: width of the digit-scan prescaler. One digit slot = 2^SCAN_DIV clocks. Legal range 3..24.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous reset, active low
- in_valid  input  1  producer offers bcd_in/dp_in/blank_in
- in_ready  output  1  pending buffer empty; transfer when in_valid && in_ready
- bcd_in  input  16  packed BCD; [3:0] = digit0 (rightmost), [15:12] = digit3
- dp_in  input  4  decimal point per digit, 1 = lit
- blank_in  input  1  leading-zero blanking enable for this word
- seg_n  output  7  segments {g,f,e,d,c,b,a}, active low
- dp_n  output  1  decimal point, active low
- dig_n  output  4  digit enables, active low, one-hot-zero
- err  output  1  sticky: a nibble >9 was accepted

Behaviour:
- Async reset clears state:
  - pre=0, idx=0, pending empty, shadow word=0, shadow dp=0, shadow blank=0, err=0.
  - Outputs during reset: in_ready=1, dig_n=4'b1111, seg_n=7'h7F, dp_n=1.
- Prescaler and scan:
  - pre (SCAN_DIV bits) increments every clk and wraps.
  - tick = (pre == all ones).
  - On tick, idx advances 0→1→2→3→0.
  - frame_end = tick && idx==3.
- Outputs are registered from next-state values:
  - Dead cycle (cycle where pre==0): dig_n=1111, seg_n=7F, dp_n=1.
  - All other cycles: dig_n[idx]=0 with all other bits 1; seg_n/dp_n show shadow digit idx.
- Handshake:
  - in_ready = !pending_full.
  - On transfer: pending captures bcd_in, dp_in and blank_in; pending_full=1.
  - On frame_end with pending_full: shadow ← pending; pending_full=0. in_ready returns to 1 the next cycle.
  - Transfer and frame_end in the same cycle with pending previously empty: the word lands in pending only and reaches shadow at the following frame_end.
  - Shadow never changes mid-frame, so no tearing.
- Latency: an accepted word is first visible at digit0 of the first full frame after the next frame_end.
- Decode (seg_n hex, bit6=g):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Any nibble 10..15 displays "E" = 06.
- Leading-zero blanking (shadow blank=1):
  - Digit k in 3..1 shows seg_n=7F if it and all higher digits are 0.
  - Digit0 is never blanked.
  - dp still follows shadow dp.
- err is set in the cycle after a transfer where any nibble of bcd_in is >9. It is cleared only by rst_n.
- Reset asserted mid-frame: outputs change immediately (async). Pending data is discarded.

Optional Feature:
- Macro SCAN_DIMMING_EN.
- When defined:
  - Adds input port bright [1:0].
  - A digit is lit only in non-dead cycles where pre[SCAN_DIV-1:SCAN_DIV-2] <= bright. Otherwise dig_n=1111, seg_n=7F, dp_n=1.
  - bright=3 gives full duty; bright=0 gives 1/4 duty.
  - bright is sampled every cycle and needs no handshake.
- When undefined: no bright port; full duty as described above.

Test Plan:
- SCAN_DIV=4 throughout: 16 clk per digit, 64 clk per frame.
- Reset: pulse rst_n low mid-digit → dig_n=1111, seg_n=7F, dp_n=1, in_ready=1, err=0 with no clock edge; after release, display shows "0000" (seg_n=40 on every digit).
- Load 0x1234, dp_in=0100, blank_in=0 → after next frame_end:
  - digit0: dig_n=1110, seg_n=19
  - digit2: dig_n=1011, seg_n=24, dp_n=0
  - digit3: dig_n=0111, seg_n=79
  - every pre==0 cycle: dig_n=1111
- Load 0x0070, blank_in=1 → digit3 and digit2 seg_n=7F; digit1 seg_n=78; digit0 seg_n=40.
- Back-to-back loads 0x1111 then 0x2222 with in_valid held →
  - in_ready drops after the first transfer.
  - The second word transfers only after the next frame_end.
  - The frame after that shows 1111; the following frame shows 2222; no frame mixes digits from both words.
- Load 0x00A5 → digit1 seg_n=06, err=1; err stays 1 after a subsequent 0x0005 load until rst_n.
- With SCAN_DIMMING_EN defined, bright=0 → per digit slot, dig_n is active only for pre=1..3 (3 cycles); bright=3 → active for pre=1..15.
